// File: rtl/flocra_axi_master.sv
// AXI4-Lite initiator for the flocra s0_axi slave: one outstanding command at a
// time, with a per-transaction cycle budget and a drain phase for late beats.
module flocra_axi_master #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_write_o,
  output logic [DATA_WIDTH-1:0]     rsp_data_o,
  output logic [1:0]                rsp_resp_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [ADDR_WIDTH-1:0]     m0_axi_awaddr,
  output logic [2:0]                m0_axi_awprot,
  output logic                      m0_axi_awvalid,
  input  logic                      m0_axi_awready,
  output logic [DATA_WIDTH-1:0]     m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m0_axi_wstrb,
  output logic                      m0_axi_wvalid,
  input  logic                      m0_axi_wready,
  input  logic [1:0]                m0_axi_bresp,
  input  logic                      m0_axi_bvalid,
  output logic                      m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m0_axi_araddr,
  output logic [2:0]                m0_axi_arprot,
  output logic                      m0_axi_arvalid,
  input  logic                      m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m0_axi_rdata,
  input  logic [1:0]                m0_axi_rresp,
  input  logic                      m0_axi_rvalid,
  output logic                      m0_axi_rready
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RSP, S_DRAIN} state_t;

  state_t               state;
  logic                 cmd_rdy_q;
  logic                 wr_q;
  logic                 drain_q;
  logic                 aw_done, w_done, ar_done;
  logic [CNT_WIDTH-1:0] cnt;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_done_n, w_done_n, ar_done_n, timeout_hit;

  assign aw_hs     = m0_axi_awvalid & m0_axi_awready;
  assign w_hs      = m0_axi_wvalid  & m0_axi_wready;
  assign ar_hs     = m0_axi_arvalid & m0_axi_arready;
  assign b_hs      = m0_axi_bvalid  & m0_axi_bready;
  assign r_hs      = m0_axi_rvalid  & m0_axi_rready;
  assign aw_done_n = aw_done | aw_hs;
  assign w_done_n  = w_done  | w_hs;
  assign ar_done_n = ar_done | ar_hs;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Ready is forced low while reset is held so nothing is accepted in that cycle.
  assign cmd_ready_o   = cmd_rdy_q & ~rst;
  assign m0_axi_awprot = 3'b000;
  assign m0_axi_arprot = 3'b000;
  assign m0_axi_wstrb  = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cmd_rdy_q      <= 1'b1;
      busy_o         <= 1'b0;
      wr_q           <= 1'b0;
      drain_q        <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      ar_done        <= 1'b0;
      cnt            <= '0;
      m0_axi_awaddr  <= '0;
      m0_axi_awvalid <= 1'b0;
      m0_axi_wdata   <= '0;
      m0_axi_wvalid  <= 1'b0;
      m0_axi_bready  <= 1'b0;
      m0_axi_araddr  <= '0;
      m0_axi_arvalid <= 1'b0;
      m0_axi_rready  <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_write_o    <= 1'b0;
      rsp_data_o     <= '0;
      rsp_resp_o     <= 2'b00;
      rsp_timeout_o  <= 1'b0;
    end else begin
      // Address/data channels retire on their own handshake in any state.
      if (aw_hs) begin
        m0_axi_awvalid <= 1'b0;
        aw_done        <= 1'b1;
      end
      if (w_hs) begin
        m0_axi_wvalid <= 1'b0;
        w_done        <= 1'b1;
      end
      if (ar_hs) begin
        m0_axi_arvalid <= 1'b0;
        ar_done        <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_rdy_q) begin
            cmd_rdy_q <= 1'b0;
            busy_o    <= 1'b1;
            wr_q      <= cmd_write_i;
            cnt       <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_done   <= 1'b0;
            if (cmd_write_i) begin
              state          <= S_WRITE;
              m0_axi_awaddr  <= cmd_addr_i;
              m0_axi_wdata   <= cmd_wdata_i;
              m0_axi_awvalid <= 1'b1;
              m0_axi_wvalid  <= 1'b1;
            end else begin
              state          <= S_READ;
              m0_axi_araddr  <= cmd_addr_i;
              m0_axi_arvalid <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (b_hs) begin
            state         <= S_RSP;
            m0_axi_bready <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_write_o   <= 1'b1;
            rsp_data_o    <= '0;
            rsp_resp_o    <= m0_axi_bresp;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit) begin
            state         <= S_RSP;
            drain_q       <= 1'b1;
            m0_axi_bready <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_write_o   <= 1'b1;
            rsp_data_o    <= '0;
            rsp_resp_o    <= 2'b00;
            rsp_timeout_o <= 1'b1;
          end else begin
            cnt           <= cnt + CNT_WIDTH'(1);
            m0_axi_bready <= aw_done_n & w_done_n;
          end
        end

        S_READ: begin
          if (r_hs) begin
            state         <= S_RSP;
            m0_axi_rready <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_write_o   <= 1'b0;
            rsp_data_o    <= m0_axi_rdata;
            rsp_resp_o    <= m0_axi_rresp;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit) begin
            state         <= S_RSP;
            drain_q       <= 1'b1;
            m0_axi_rready <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_write_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_resp_o    <= 2'b00;
            rsp_timeout_o <= 1'b1;
          end else begin
            cnt           <= cnt + CNT_WIDTH'(1);
            m0_axi_rready <= ar_done_n;
          end
        end

        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (drain_q) begin
              state         <= S_DRAIN;
              m0_axi_bready <= wr_q & aw_done_n & w_done_n;
              m0_axi_rready <= ~wr_q & ar_done_n;
            end else begin
              state     <= S_IDLE;
              cmd_rdy_q <= 1'b1;
              busy_o    <= 1'b0;
            end
          end
        end

        // Swallow the late B/R beat of a timed-out transaction.
        S_DRAIN: begin
          if ((wr_q && b_hs) || (!wr_q && r_hs)) begin
            state         <= S_IDLE;
            drain_q       <= 1'b0;
            m0_axi_bready <= 1'b0;
            m0_axi_rready <= 1'b0;
            cmd_rdy_q     <= 1'b1;
            busy_o        <= 1'b0;
          end else begin
            m0_axi_bready <= wr_q & aw_done_n & w_done_n;
            m0_axi_rready <= ~wr_q & ar_done_n;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flocra_axi_master.sv
// Bench for flocra_axi_master: behavioural AXI-Lite slave with programmable
// delays, a directed vector table, corner-case sequences and a random phase.
module tb_flocra_axi_master;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  flocra_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_data_o(rsp_data), .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .busy_o(busy),
    .m0_axi_awaddr(awaddr), .m0_axi_awprot(awprot), .m0_axi_awvalid(awvalid),
    .m0_axi_awready(awready), .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb),
    .m0_axi_wvalid(wvalid), .m0_axi_wready(wready), .m0_axi_bresp(bresp),
    .m0_axi_bvalid(bvalid), .m0_axi_bready(bready), .m0_axi_araddr(araddr),
    .m0_axi_arprot(arprot), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid),
    .m0_axi_rready(rready)
  );

  // Slave behaviour knobs, changed only between transactions.
  int         k_aw, k_w, k_ar, k_b, k_r;
  logic [1:0] k_resp;

  logic [31:0]   smem [0:255];
  int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic          aw_got, w_got, ar_got;
  logic [AW-1:0] s_awaddr, s_araddr, wa_eff, ra_eff;
  logic [DW-1:0] s_wdata, wd_eff;
  logic          aw_hs, w_hs, ar_hs;

  assign awready = awvalid && !aw_got && (aw_cnt >= k_aw);
  assign wready  = wvalid  && !w_got  && (w_cnt  >= k_w);
  assign arready = arvalid && !ar_got && (ar_cnt >= k_ar);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid  && wready;
  assign ar_hs   = arvalid && arready;
  assign wa_eff  = aw_hs ? awaddr : s_awaddr;
  assign wd_eff  = w_hs  ? wdata  : s_wdata;
  assign ra_eff  = ar_hs ? araddr : s_araddr;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; end
      else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; s_wdata <= wdata; w_cnt <= 0; end
      else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
      if (ar_hs) begin ar_got <= 1'b1; s_araddr <= araddr; ar_cnt <= 0; end
      else if (arvalid && !ar_got) ar_cnt <= ar_cnt + 1;

      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
        if (b_cnt >= k_b) begin
          bvalid <= 1'b1;
          bresp  <= k_resp;
          smem[wa_eff[9:2]] <= wd_eff;
        end else b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end

      if ((ar_got || ar_hs) && !rvalid) begin
        if (r_cnt >= k_r) begin
          rvalid <= 1'b1;
          rresp  <= k_resp;
          rdata  <= smem[ra_eff[9:2]];
        end else r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
      end
    end
  end

  // Free-running cycle and handshake counters.
  int cyc = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_hs) n_aw <= n_aw + 1;
    if (w_hs) n_w <= n_w + 1;
    if (bvalid && bready) n_b <= n_b + 1;
    if (ar_hs) n_ar <= n_ar + 1;
    if (rvalid && rready) n_r <= n_r + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            aw_d, w_d, ar_d, b_d, r_d;
    logic [1:0]    sresp;
    int            hold;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    logic          exp_to;
    int            exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int aw_d, input int w_d, input int ar_d, input int b_d,
                              input int r_d, input logic [1:0] sresp, input int hold,
                              input logic [DW-1:0] ed, input logic [1:0] er, input logic et,
                              input int el);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d;
    v.aw_d = aw_d; v.w_d = w_d; v.ar_d = ar_d; v.b_d = b_d; v.r_d = r_d;
    v.sresp = sresp; v.hold = hold;
    v.exp_data = ed; v.exp_resp = er; v.exp_to = et; v.exp_lat = el;
    return v;
  endfunction

  // Per-cycle trace of the current transaction, indexed by cycles since accept.
  logic tr_aw [0:63];
  logic tr_w  [0:63];
  logic tr_br [0:63];
  logic tr_ar [0:63];
  logic tr_cr [0:63];

  task automatic rec(input int k);
    if (k >= 0 && k < 64) begin
      tr_aw[k] = awvalid; tr_w[k] = wvalid; tr_br[k] = bready;
      tr_ar[k] = arvalid; tr_cr[k] = cmd_ready;
    end
  endtask

  // Reference memory: what the slave should hold after each completed write.
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : '0;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int t0, k, lat, extra;
    int a0, w0, b0, r0, q0;
    bit seen;
    k_aw = v.aw_d; k_w = v.w_d; k_ar = v.ar_d; k_b = v.b_d; k_r = v.r_d; k_resp = v.sresp;
    a0 = n_aw; w0 = n_w; b0 = n_b; r0 = n_ar; q0 = n_r;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk($sformatf("%s.accept", tag), 64'(cmd_ready), 64'd1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    t0 = cyc;
    rec(0);
    seen = 0; lat = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
      rec(cyc - t0);
      if (rsp_valid) begin seen = 1; lat = cyc - t0; end
    end
    chk($sformatf("%s.rsp_seen", tag), 64'(seen), 64'd1);
    if (!seen) return;
    chk($sformatf("%s.lat", tag), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("%s.write", tag), 64'(rsp_write), 64'(v.wr));
    chk($sformatf("%s.data", tag), 64'(rsp_data), 64'(v.exp_data));
    chk($sformatf("%s.resp", tag), 64'(rsp_resp), 64'(v.exp_resp));
    chk($sformatf("%s.timeout", tag), 64'(rsp_timeout), 64'(v.exp_to));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      rec(cyc - t0);
      chk($sformatf("%s.hold%0d", tag, h),
          64'({rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_data, cmd_ready, awvalid | wvalid | arvalid}),
          64'({1'b1, v.wr, v.exp_resp, v.exp_to, v.exp_data, 1'b0, 1'b0}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    rec(cyc - t0);
    extra = rsp_valid ? 1 : 0;
    k = 0;
    while (!cmd_ready && k < 60) begin
      @(negedge clk);
      rec(cyc - t0);
      if (rsp_valid) extra++;
      k++;
    end
    chk($sformatf("%s.idle", tag), 64'(cmd_ready), 64'd1);
    chk($sformatf("%s.extra_rsp", tag), 64'(extra), 64'd0);
    chk($sformatf("%s.n_aw", tag), 64'(n_aw - a0), 64'(v.wr));
    chk($sformatf("%s.n_w", tag), 64'(n_w - w0), 64'(v.wr));
    chk($sformatf("%s.n_b", tag), 64'(n_b - b0), 64'(v.wr));
    chk($sformatf("%s.n_ar", tag), 64'(n_ar - r0), 64'(!v.wr));
    chk($sformatf("%s.n_r", tag), 64'(n_r - q0), 64'(!v.wr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [0:6];
    vec_t v;
    int   mx;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    k_aw = 0; k_w = 0; k_ar = 0; k_b = 0; k_r = 0; k_resp = 2'b00;

    tbl[0] = mk(1'b1, 19'h10, 32'h1234ABCD, 0, 0, 0, 0, 0, 2'b00,  0, 32'h0,        2'b00, 1'b0, 3);
    tbl[1] = mk(1'b0, 19'h10, 32'h0,        0, 0, 0, 0, 0, 2'b00, 10, 32'h1234ABCD, 2'b00, 1'b0, 3);
    tbl[2] = mk(1'b1, 19'h20, 32'hCAFEF00D, 5, 0, 0, 0, 0, 2'b00,  0, 32'h0,        2'b00, 1'b0, 8);
    tbl[3] = mk(1'b0, 19'h20, 32'h0,        0, 0, 2, 0, 1, 2'b00,  0, 32'hCAFEF00D, 2'b00, 1'b0, 6);
    tbl[4] = mk(1'b1, 19'h30, 32'h55AA55AA, 0, 3, 0, 1, 0, 2'b10,  2, 32'h0,        2'b10, 1'b0, 7);
    tbl[5] = mk(1'b0, 19'h30, 32'h0,        0, 0, 0, 0, 0, 2'b10,  0, 32'h55AA55AA, 2'b10, 1'b0, 3);
    tbl[6] = mk(1'b0, 19'h40, 32'h0,        0, 0, 1, 0, 2, 2'b00,  1, 32'h0,        2'b00, 1'b0, 6);

    // Reset values while reset is held.
    @(negedge clk); @(negedge clk);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst.rsp", 64'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_data}), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.axi", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst.const", 64'({awprot, arprot, wstrb}), 64'h00F);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].wr) exp_mem[tbl[i].addr] = tbl[i].data;
      if (i == 2) begin
        chk("skew.w_c1", 64'(tr_w[1]), 64'd1);
        chk("skew.w_c2", 64'(tr_w[2]), 64'd0);
        chk("skew.aw_c6", 64'(tr_aw[6]), 64'd1);
        chk("skew.aw_c7", 64'(tr_aw[7]), 64'd0);
        chk("skew.bready_c6", 64'(tr_br[6]), 64'd0);
        chk("skew.bready_c7", 64'(tr_br[7]), 64'd1);
      end
    end

    // Read whose AR is withheld past the budget: timeout response, then drain.
    v = mk(1'b0, 19'h50, 32'h0, 0, 0, 19, 0, 0, 2'b00, 0, 32'h0, 2'b00, 1'b1, 9);
    run(v, "tmo");
    chk("tmo.ar_c20", 64'(tr_ar[20]), 64'd1);
    chk("tmo.ar_c21", 64'(tr_ar[21]), 64'd0);
    chk("tmo.crdy_c21", 64'(tr_cr[21]), 64'd0);
    chk("tmo.crdy_c22", 64'(tr_cr[22]), 64'd1);

    // Reset pulsed while a read is waiting for AR.
    k_ar = 10; k_r = 0; k_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 19'h10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.arvalid_before", 64'(arvalid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    chk("rstmid.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    exp_mem.delete();
    @(negedge clk);
    chk("rstmid.cmd_ready", 64'(cmd_ready), 64'd1);
    v = mk(1'b1, 19'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 1'b0, 3);
    run(v, "rstmid.write");
    exp_mem[v.addr] = v.data;

    // Random traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = AW'($urandom_range(0, 15) * 4);
      v.data  = $urandom;
      v.aw_d  = $urandom_range(0, 2);
      v.w_d   = $urandom_range(0, 2);
      v.ar_d  = $urandom_range(0, 2);
      v.b_d   = $urandom_range(0, 2);
      v.r_d   = $urandom_range(0, 2);
      v.sresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      v.hold  = $urandom_range(0, 3);
      v.exp_resp = v.sresp;
      v.exp_to   = 1'b0;
      if (v.wr) begin
        mx = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
        v.exp_data = '0;
        v.exp_lat  = 3 + mx + v.b_d;
      end else begin
        v.exp_data = model_read(v.addr);
        v.exp_lat  = 3 + v.ar_d + v.r_d;
      end
      run(v, $sformatf("rnd%0d", i));
      if (v.wr) exp_mem[v.addr] = v.data;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
